// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI mode-0 responder.
// Optional feature macro used by this slice: SPI_SLAVE_BSYNC_EN.
package spi_slave_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
   localparam logic [2:0] BIT_FIRST     = 3'd7;
   localparam logic [2:0] BIT_AFTER_SYNC = 3'd6;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the RX FIFO / TX holding register handshake.
// Macro SPI_SLAVE_BSYNC_EN adds the bsync framing pin.
interface spi_slave_if;
   logic       sck;
   logic       mosi;
   logic       ncs;
`ifdef SPI_SLAVE_BSYNC_EN
   logic       bsync;
`endif
   logic       miso;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_pop;
   logic       rx_ovf;
   logic       rx_ovf_clr;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_empty;

   modport master (
`ifdef SPI_SLAVE_BSYNC_EN
      output bsync,
`endif
      output sck, mosi, ncs,
      output rx_pop, rx_ovf_clr,
      output tx_data, tx_load,
      input  miso, rx_data, rx_valid,
      input  rx_ovf, tx_empty
   );

   modport slave (
`ifdef SPI_SLAVE_BSYNC_EN
      input  bsync,
`endif
      input  sck, mosi, ncs,
      input  rx_pop, rx_ovf_clr,
      input  tx_data, tx_load,
      output miso, rx_data, rx_valid,
      output rx_ovf, tx_empty
   );
endinterface

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: synchronous FIFO with extra-MSB pointers.
// A pop frees the head slot so a push in the same clock succeeds when full.
module spi_slave_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_dout    = r_mem[r_rptr[AW-1:0]];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage and pointer update; pop is applied before the full test.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_do_pop) r_rptr <= r_rptr + PTR_ONE;
      end
   end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 responder with RX FIFO and TX holding reg.
// Define SPI_SLAVE_BSYNC_EN to enable bsync byte realignment.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic       i_clock,
   input logic       i_rst,
   spi_slave_if.slave bus
);
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sck_d;
   logic                   w_sck_s;
   logic                   w_mosi_s;
   logic                   w_ncs_s;
   logic                   w_bsync_s;
   logic                   w_sck_rise;
   logic                   w_sck_fall;

   state_t     r_state;
   logic [2:0] r_bitcnt;
   logic [6:0] r_shift_rx;
   logic [7:0] r_shift_tx;
   logic [7:0] r_hold;
   logic       r_tx_empty;
   logic       r_miso;
   logic       r_reload;
   logic       r_push;
   logic [7:0] r_push_data;
   logic       r_ovf;
   logic [7:0] w_tx_next;
   logic [7:0] w_rx_byte;
   logic [7:0] w_fifo_dout;
   logic       w_full;
   logic       w_empty;

   // Pin synchronisers; reset to the idle bus state (ncs high, sck low).
   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_ncs_sync  <= '1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.ncs};
      end
   end

`ifdef SPI_SLAVE_BSYNC_EN
   logic [SYNC_STAGES-1:0] r_bsync_sync;

   // bsync shares the sck pipeline delay so it lines up with the sck rise.
   always_ff @(posedge i_clock) begin
      if (i_rst) r_bsync_sync <= '0;
      else r_bsync_sync <= {r_bsync_sync[SYNC_STAGES-2:0], bus.bsync};
   end

   assign w_bsync_s = r_bsync_sync[SYNC_STAGES-1];
`else
   assign w_bsync_s = 1'b0;
`endif

   // Edge-detect flop on the synchronised sck.
   always_ff @(posedge i_clock) begin
      if (i_rst) r_sck_d <= 1'b0;
      else r_sck_d <= w_sck_s;
   end

   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
   assign w_ncs_s    = r_ncs_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck_s & ~r_sck_d;
   assign w_sck_fall = ~w_sck_s & r_sck_d;
   assign w_tx_next  = r_tx_empty ? SPI_IDLE_BYTE : r_hold;
   assign w_rx_byte  = {r_shift_rx, w_mosi_s};

   // Transfer FSM: bit framing, RX shift, TX shift and holding register.
   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_bitcnt    <= BIT_FIRST;
         r_shift_rx  <= '0;
         r_shift_tx  <= SPI_IDLE_BYTE;
         r_hold      <= '0;
         r_tx_empty  <= 1'b1;
         r_miso      <= 1'b1;
         r_reload    <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_push <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_miso   <= 1'b1;
               r_bitcnt <= BIT_FIRST;
               r_reload <= 1'b0;
               if (!w_ncs_s) begin
                  // Mode 0: first bit must be on miso before the first rise.
                  r_state    <= ST_ACTIVE;
                  r_miso     <= w_tx_next[7];
                  r_shift_tx <= {w_tx_next[6:0], 1'b1};
                  r_tx_empty <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_ncs_s) begin
                  r_state  <= ST_IDLE;
                  r_miso   <= 1'b1;
                  r_bitcnt <= BIT_FIRST;
                  r_reload <= 1'b0;
               end else begin
                  if (w_sck_rise) begin
                     r_shift_rx <= w_rx_byte[6:0];
                     if (w_bsync_s) begin
                        r_bitcnt <= BIT_AFTER_SYNC;
                     end else if (r_bitcnt == 3'd0) begin
                        r_push      <= 1'b1;
                        r_push_data <= w_rx_byte;
                        r_bitcnt    <= BIT_FIRST;
                        r_reload    <= 1'b1;
                     end else begin
                        r_bitcnt <= r_bitcnt - 3'd1;
                     end
                  end
                  if (w_sck_fall) begin
                     if (r_reload) begin
                        r_miso     <= w_tx_next[7];
                        r_shift_tx <= {w_tx_next[6:0], 1'b1};
                        r_tx_empty <= 1'b1;
                        r_reload   <= 1'b0;
                     end else begin
                        r_miso     <= r_shift_tx[7];
                        r_shift_tx <= {r_shift_tx[6:0], 1'b1};
                     end
                  end
               end
            end
         endcase
         // A load in the same clock as a reload keeps the new byte held.
         if (bus.tx_load) begin
            r_hold     <= bus.tx_data;
            r_tx_empty <= 1'b0;
         end
      end
   end

   spi_slave_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clock),
      .i_rst   (i_rst),
      .i_push  (r_push),
      .i_pop   (bus.rx_pop),
      .i_din   (r_push_data),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Sticky overrun; a new overrun beats a clear in the same clock.
   always_ff @(posedge i_clock) begin
      if (i_rst) r_ovf <= 1'b0;
      else if (r_push && w_full && !bus.rx_pop) r_ovf <= 1'b1;
      else if (bus.rx_ovf_clr) r_ovf <= 1'b0;
   end

   assign bus.miso     = r_miso;
   assign bus.rx_data  = w_fifo_dout;
   assign bus.rx_valid = ~w_empty;
   assign bus.rx_ovf   = r_ovf;
   assign bus.tx_empty = r_tx_empty;
endmodule
